// File: rtl/sipo_frame_shift_if.sv
// Serial receive port of sipo_frame_shift: serial/control inputs plus frame handshake and status.
// The slave modport is the shift register; the master modport is its driver/consumer.
interface sipo_frame_shift_if #(
   parameter int WIDTH = 4
);
   localparam int CW = $clog2(WIDTH);

   logic             Clr;
   logic             ShiftEn;
   logic             Din;
   logic             FrameAck;
   logic [WIDTH-1:0] Dout;
   logic             Sout;
   logic [CW-1:0]    BitCnt;
   logic [WIDTH-1:0] Frame;
   logic             FrameValid;
   logic             Overrun;

   modport master (
      output Clr, ShiftEn, Din, FrameAck,
      input  Dout, Sout, BitCnt, Frame, FrameValid, Overrun
   );

   modport slave (
      input  Clr, ShiftEn, Din, FrameAck,
      output Dout, Sout, BitCnt, Frame, FrameValid, Overrun
   );
endinterface

// File: rtl/sipo_frame_shift.sv
// Serial-in/parallel-out frame assembler: Frame/FrameValid appear on the edge sampling the last bit.
// FrameValid held until FrameAck; a frame landing on an unacknowledged one overwrites it and sets sticky Overrun.
module sipo_frame_shift #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b0
) (
   input  logic              Clk,
   input  logic              Rst_n,
   sipo_frame_shift_if.slave sif
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [WIDTH-1:0] sr;
   logic [WIDTH-1:0] sr_nxt;
   logic [CW-1:0]    bit_cnt;
   logic [WIDTH-1:0] frame;
   logic             frame_vld;
   logic             overrun;
   logic             complete;

   // Post-shift word, so the completing edge captures the bit sampled on that same edge.
   always_comb begin
      sr_nxt = sr;
      if (MSB_FIRST) begin
         sr_nxt = {sr[WIDTH-2:0], sif.Din};
      end else begin
         sr_nxt = {sif.Din, sr[WIDTH-1:1]};
      end
   end

   assign complete = sif.ShiftEn && !sif.Clr && (bit_cnt == LAST);

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sr        <= '0;
         bit_cnt   <= '0;
         frame     <= '0;
         frame_vld <= 1'b0;
         overrun   <= 1'b0;
      end else if (sif.Clr) begin
         sr        <= '0;
         bit_cnt   <= '0;
         frame_vld <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         if (sif.ShiftEn) begin
            sr      <= sr_nxt;
            bit_cnt <= (bit_cnt == LAST) ? '0 : bit_cnt + CW'(1);
         end
         // A completing frame wins over an ack on the same edge.
         if (complete) begin
            frame     <= sr_nxt;
            frame_vld <= 1'b1;
            if (frame_vld && !sif.FrameAck) begin
               overrun <= 1'b1;
            end
         end else if (sif.FrameAck) begin
            frame_vld <= 1'b0;
         end
      end
   end

   assign sif.Dout       = sr;
   assign sif.Sout       = MSB_FIRST ? sr[WIDTH-1] : sr[0];
   assign sif.BitCnt     = bit_cnt;
   assign sif.Frame      = frame;
   assign sif.FrameValid = frame_vld;
   assign sif.Overrun    = overrun;
endmodule

// File: tb/tb_sipo_frame_shift.sv
// Bench for sipo_frame_shift: LSB/MSB-first, gapped enable, handshake/overrun, clear/reset, cascade.
module tb_sipo_frame_shift;
   typedef struct packed {
      logic [31:0] frame;
      logic        ovr;
   } exp_t;

   logic Clk;
   logic Rst_n;
   int   vectors     = 0;
   int   miscompares = 0;
   exp_t q_l[$];
   exp_t q_m[$];
   exp_t q_8[$];

   sipo_frame_shift_if #(.WIDTH(4)) if_l ();
   sipo_frame_shift_if #(.WIDTH(4)) if_m ();
   sipo_frame_shift_if #(.WIDTH(8)) if_8 ();
   sipo_frame_shift_if #(.WIDTH(4)) if_a ();
   sipo_frame_shift_if #(.WIDTH(4)) if_b ();

   sipo_frame_shift #(.WIDTH(4), .MSB_FIRST(1'b0)) u_l (.Clk(Clk), .Rst_n(Rst_n), .sif(if_l.slave));
   sipo_frame_shift #(.WIDTH(4), .MSB_FIRST(1'b1)) u_m (.Clk(Clk), .Rst_n(Rst_n), .sif(if_m.slave));
   sipo_frame_shift #(.WIDTH(8), .MSB_FIRST(1'b0)) u_8 (.Clk(Clk), .Rst_n(Rst_n), .sif(if_8.slave));
   sipo_frame_shift #(.WIDTH(4), .MSB_FIRST(1'b0)) u_a (.Clk(Clk), .Rst_n(Rst_n), .sif(if_a.slave));
   sipo_frame_shift #(.WIDTH(4), .MSB_FIRST(1'b0)) u_b (.Clk(Clk), .Rst_n(Rst_n), .sif(if_b.slave));

   // Second cascade stage follows the first one's serial output and controls.
   assign if_b.Din      = if_a.Sout;
   assign if_b.ShiftEn  = if_a.ShiftEn;
   assign if_b.Clr      = if_a.Clr;
   assign if_b.FrameAck = if_a.FrameAck;

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic frame_chk(input string nm, input bit have, input exp_t e, input logic [31:0] fr,
                            input logic vld, input logic ovr, input logic [31:0] cnt);
      if (!have) begin
         vectors++;
         miscompares++;
         $display("FAIL %s unexpected frame: got %0h expected none", nm, fr);
      end else begin
         chk({nm, " frame"}, fr, e.frame);
         chk({nm, " valid"}, 32'(vld), 32'h1);
         chk({nm, " overrun"}, 32'(ovr), 32'(e.ovr));
         chk({nm, " bitcnt wrap"}, cnt, 32'h0);
      end
   endtask

   // Monitors: a completing edge is seen on the interface, the result is checked half a cycle later.
   initial begin : mon_l
      bit   hit;
      exp_t e;
      forever begin
         @(posedge Clk);
         hit = Rst_n && if_l.ShiftEn && !if_l.Clr && (if_l.BitCnt == 2'd3);
         if (hit) begin
            @(negedge Clk);
            e = '0;
            if (q_l.size() != 0) e = q_l.pop_front();
            else hit = 1'b0;
            frame_chk("u_l", hit, e, 32'(if_l.Frame), if_l.FrameValid, if_l.Overrun, 32'(if_l.BitCnt));
         end
      end
   end

   initial begin : mon_m
      bit   hit;
      exp_t e;
      forever begin
         @(posedge Clk);
         hit = Rst_n && if_m.ShiftEn && !if_m.Clr && (if_m.BitCnt == 2'd3);
         if (hit) begin
            @(negedge Clk);
            e = '0;
            if (q_m.size() != 0) e = q_m.pop_front();
            else hit = 1'b0;
            frame_chk("u_m", hit, e, 32'(if_m.Frame), if_m.FrameValid, if_m.Overrun, 32'(if_m.BitCnt));
         end
      end
   end

   initial begin : mon_8
      bit   hit;
      exp_t e;
      forever begin
         @(posedge Clk);
         hit = Rst_n && if_8.ShiftEn && !if_8.Clr && (if_8.BitCnt == 3'd7);
         if (hit) begin
            @(negedge Clk);
            e = '0;
            if (q_8.size() != 0) e = q_8.pop_front();
            else hit = 1'b0;
            frame_chk("u_8", hit, e, 32'(if_8.Frame), if_8.FrameValid, if_8.Overrun, 32'(if_8.BitCnt));
         end
      end
   end

   // Each step drives one edge, then returns the controls to idle.
   task automatic step_l(input bit en, input bit d, input bit ack, input bit clr);
      if_l.ShiftEn = en; if_l.Din = d; if_l.FrameAck = ack; if_l.Clr = clr;
      @(negedge Clk);
      if_l.ShiftEn = 1'b0; if_l.FrameAck = 1'b0; if_l.Clr = 1'b0;
   endtask

   task automatic step_m(input bit en, input bit d);
      if_m.ShiftEn = en; if_m.Din = d;
      @(negedge Clk);
      if_m.ShiftEn = 1'b0;
   endtask

   task automatic step_8(input bit en, input bit d);
      if_8.ShiftEn = en; if_8.Din = d;
      @(negedge Clk);
      if_8.ShiftEn = 1'b0;
   endtask

   task automatic step_a(input bit d);
      if_a.ShiftEn = 1'b1; if_a.Din = d;
      @(negedge Clk);
      if_a.ShiftEn = 1'b0;
   endtask

   initial begin : stim
      logic [7:0] byte_v;
      logic [2:0] cnt_v;

      Rst_n = 1'b0;
      if_l.ShiftEn = 1'b0; if_l.Din = 1'b0; if_l.FrameAck = 1'b0; if_l.Clr = 1'b0;
      if_m.ShiftEn = 1'b0; if_m.Din = 1'b0; if_m.FrameAck = 1'b0; if_m.Clr = 1'b0;
      if_8.ShiftEn = 1'b0; if_8.Din = 1'b0; if_8.FrameAck = 1'b0; if_8.Clr = 1'b0;
      if_a.ShiftEn = 1'b0; if_a.Din = 1'b0; if_a.FrameAck = 1'b0; if_a.Clr = 1'b0;
      repeat (2) @(negedge Clk);
      chk("reset Dout", 32'(if_l.Dout), 32'h0);
      chk("reset Sout", 32'(if_l.Sout), 32'h0);
      chk("reset BitCnt", 32'(if_l.BitCnt), 32'h0);
      chk("reset Frame", 32'(if_l.Frame), 32'h0);
      chk("reset FrameValid", 32'(if_l.FrameValid), 32'h0);
      chk("reset Overrun", 32'(if_l.Overrun), 32'h0);
      Rst_n = 1'b1;
      @(negedge Clk);

      // LSB-first 1,1,0,1 -> 4'b1011
      q_l.push_back('{frame: 32'hB, ovr: 1'b0});
      step_l(1, 1, 0, 0); step_l(1, 1, 0, 0); step_l(1, 0, 0, 0); step_l(1, 1, 0, 0);
      step_l(0, 0, 1, 0);
      chk("ack clears FrameValid", 32'(if_l.FrameValid), 32'h0);

      // MSB-first 1,0,1,1 -> 4'b1011, partial Dout after two edges
      q_m.push_back('{frame: 32'hB, ovr: 1'b0});
      step_m(1, 1); step_m(1, 0);
      chk("msb Dout after 2", 32'(if_m.Dout), 32'h2);
      step_m(1, 1); step_m(1, 1);

      // 0xA5 LSB-first on an 8-bit instance with an idle cycle after every enabled edge
      byte_v = 8'hA5;
      q_8.push_back('{frame: 32'hA5, ovr: 1'b0});
      for (int i = 0; i < 8; i++) begin
         cnt_v = 3'(i + 1);
         step_8(1, byte_v[i]);
         chk($sformatf("gap BitCnt shift %0d", i), 32'(if_8.BitCnt), 32'(cnt_v));
         step_8(0, ~byte_v[i]);
         chk($sformatf("gap BitCnt idle %0d", i), 32'(if_8.BitCnt), 32'(cnt_v));
      end

      // Back-to-back 4'h3 then 4'hC without ack -> overrun
      q_l.push_back('{frame: 32'h3, ovr: 1'b0});
      q_l.push_back('{frame: 32'hC, ovr: 1'b1});
      step_l(1, 1, 0, 0); step_l(1, 1, 0, 0); step_l(1, 0, 0, 0); step_l(1, 0, 0, 0);
      step_l(1, 0, 0, 0); step_l(1, 0, 0, 0); step_l(1, 1, 0, 0); step_l(1, 1, 0, 0);
      step_l(0, 0, 0, 1);
      chk("clr Overrun", 32'(if_l.Overrun), 32'h0);
      chk("clr FrameValid", 32'(if_l.FrameValid), 32'h0);
      chk("clr keeps Frame", 32'(if_l.Frame), 32'hC);

      // Same pair with ack on the completing edge of the second frame
      q_l.push_back('{frame: 32'h3, ovr: 1'b0});
      q_l.push_back('{frame: 32'hC, ovr: 1'b0});
      step_l(1, 1, 0, 0); step_l(1, 1, 0, 0); step_l(1, 0, 0, 0); step_l(1, 0, 0, 0);
      step_l(1, 0, 0, 0); step_l(1, 0, 0, 0); step_l(1, 1, 0, 0); step_l(1, 1, 1, 0);
      step_l(0, 0, 1, 0);

      // Clr after 2 of 4 bits, with a Din sampled on the clear edge that must be dropped
      step_l(1, 1, 0, 0); step_l(1, 0, 0, 0);
      chk("mid BitCnt", 32'(if_l.BitCnt), 32'h2);
      step_l(1, 1, 0, 1);
      chk("clr BitCnt", 32'(if_l.BitCnt), 32'h0);
      chk("clr Dout", 32'(if_l.Dout), 32'h0);
      chk("clr retains Frame", 32'(if_l.Frame), 32'hC);
      q_l.push_back('{frame: 32'h6, ovr: 1'b0});
      step_l(1, 0, 0, 0); step_l(1, 1, 0, 0); step_l(1, 1, 0, 0); step_l(1, 0, 0, 0);

      // Cascade: 8'h5A LSB-first through two chained stages
      byte_v = 8'h5A;
      for (int i = 0; i < 8; i++) step_a(byte_v[i]);
      chk("cascade first Dout", 32'(if_a.Dout), 32'h5);
      chk("cascade second Dout", 32'(if_b.Dout), 32'hA);

      // Reset asserted between edges, mid-frame
      step_l(1, 1, 0, 0); step_l(1, 1, 0, 0);
      #2 Rst_n = 1'b0;
      #1;
      chk("async Dout", 32'(if_l.Dout), 32'h0);
      chk("async Sout", 32'(if_l.Sout), 32'h0);
      chk("async BitCnt", 32'(if_l.BitCnt), 32'h0);
      chk("async Frame", 32'(if_l.Frame), 32'h0);
      chk("async FrameValid", 32'(if_l.FrameValid), 32'h0);
      chk("async Overrun", 32'(if_l.Overrun), 32'h0);
      @(negedge Clk);
      Rst_n = 1'b1;
      @(negedge Clk);
      q_l.push_back('{frame: 32'h9, ovr: 1'b0});
      step_l(1, 1, 0, 0); step_l(1, 0, 0, 0); step_l(1, 0, 0, 0); step_l(1, 1, 0, 0);
      chk("Sout after frame", 32'(if_l.Sout), 32'h1);

      repeat (3) @(negedge Clk);
      chk("u_l queue drained", 32'(q_l.size()), 32'h0);
      chk("u_m queue drained", 32'(q_m.size()), 32'h0);
      chk("u_8 queue drained", 32'(q_8.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
